// File: rtl/divider_pkg.sv
// Shared types and helpers for the radix-2 non-restoring signed divider.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam int unsigned DEF_N = 32;

  // Most negative operand for the default width
  localparam logic [DEF_N-1:0] MIN_VAL = DEF_N'(1) << (DEF_N - 1);

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Start/done handshake and operand/result bus between datapath control and the divider.
interface nonrestoring_divider_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, Dividend, Divisor,
    input  busy, done, Quotient, Remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, Dividend, Divisor,
    output busy, done, Quotient, Remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/nonrestoring_step.sv
// One non-restoring iteration: shift {P,Q} left, add or subtract |Divisor| by the sign of P.
module nonrestoring_step #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   i_p,
  input  logic         i_q_msb,
  input  logic [N-1:0] i_dvs,
  output logic [N:0]   o_p_new_c,
  output logic         o_q_bit_c
);

  logic [N:0] w_p_sh;
  logic [N:0] w_dvs_ext;

  always_comb begin
    w_p_sh    = {i_p[N-1:0], i_q_msb};
    w_dvs_ext = {1'b0, i_dvs};
    o_p_new_c = i_p[N] ? (w_p_sh + w_dvs_ext) : (w_p_sh - w_dvs_ext);
    o_q_bit_c = ~o_p_new_c[N];
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle signed divider: one quotient bit per clock, quotient truncated toward zero,
// remainder carries the sign of the dividend.
module nonrestoring_divider
  import divider_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  nonrestoring_divider_if.slave bus
);

  localparam int unsigned   CW     = cnt_width(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [N-1:0]  MIN_N  = {1'b1, {(N-1){1'b0}}};

  state_t        r_state;
  logic [N-1:0]  r_dividend;
  logic [N-1:0]  r_divisor;
  logic [N:0]    r_p;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_dz;
  logic          r_ovf;

  logic [N-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic [N:0]    w_p_new;
  logic          w_q_bit;
  logic [N:0]    w_p_fix;
  logic [N-1:0]  w_quo;
  logic [N-1:0]  w_rem;

  nonrestoring_step #(.N(N)) u_step (
    .i_p       (r_p),
    .i_q_msb   (r_q[N-1]),
    .i_dvs     (r_dvs),
    .o_p_new_c (w_p_new),
    .o_q_bit_c (w_q_bit)
  );

  // Magnitudes as unsigned N-bit values; |MIN| wraps to 2^(N-1), which is what we want
  always_comb begin
    w_abs_a = r_dividend[N-1] ? (-r_dividend) : r_dividend;
    w_abs_b = r_divisor[N-1]  ? (-r_divisor)  : r_divisor;
    w_p_fix = r_p[N] ? (r_p + {1'b0, r_dvs}) : r_p;
    w_quo   = r_sign_q ? (-r_q) : r_q;
    w_rem   = r_sign_r ? (-w_p_fix[N-1:0]) : w_p_fix[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_dividend      <= '0;
      r_divisor       <= '0;
      r_p             <= '0;
      r_q             <= '0;
      r_dvs           <= '0;
      r_cnt           <= '0;
      r_sign_q        <= 1'b0;
      r_sign_r        <= 1'b0;
      r_dz            <= 1'b0;
      r_ovf           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.Quotient    <= '0;
      bus.Remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.Dividend;
            r_divisor  <= bus.Divisor;
            bus.busy   <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          r_p      <= '0;
          r_q      <= w_abs_a;
          r_dvs    <= w_abs_b;
          r_cnt    <= '0;
          r_sign_q <= r_dividend[N-1] ^ r_divisor[N-1];
          r_sign_r <= r_dividend[N-1];
          r_dz     <= (r_divisor == '0);
          r_ovf    <= (r_dividend == MIN_N) && (r_divisor == '1);
          // A zero divisor skips the iterations; FIX then emits the fixed result pattern
          r_state  <= (r_divisor == '0) ? FIX : ITER;
        end
        ITER: begin
          r_p   <= w_p_new;
          r_q   <= {r_q[N-2:0], w_q_bit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          bus.Quotient    <= r_dz ? '1 : w_quo;
          bus.Remainder   <= r_dz ? r_dividend : w_rem;
          bus.div_by_zero <= r_dz;
          bus.overflow    <= r_ovf;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          r_state         <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and randomised checks of the signed non-restoring divider at N=32.
module tb_nonrestoring_divider;

  localparam int unsigned N = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nonrestoring_divider_if #(.N(N)) bus ();

  nonrestoring_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: language-level signed division with the two special cases patched in
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; ov = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0; dz = 1'b0; ov = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0; ov = 1'b0;
    end
  endfunction

  // Issues one start and waits (bounded) for done; returns results, latency and busy cycles
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic ov,
                        output int lat, output int bcnt);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.Dividend = a; bus.Divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.Dividend = 32'hDEAD_BEEF; bus.Divisor = 32'h0000_0003;
    bcnt = bus.busy ? 1 : 0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done && bus.busy) bcnt++;
    end
    q = bus.Quotient; r = bus.Remainder; dz = bus.div_by_zero; ov = bus.overflow;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: busy/done/dz/ov=%b required 0000",
               {bus.busy, bus.done, bus.div_by_zero, bus.overflow});
    end
    checks++;
    if (bus.Quotient !== 32'h0 || bus.Remainder !== 32'h0) begin
      failures++;
      $display("FAIL reset_results: q=%h r=%h required 0 0", bus.Quotient, bus.Remainder);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] eq [12];
    logic [31:0] er [12];
    logic [1:0]  ef [12];
    logic [31:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    va = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'd7, 32'h8000_0000,
           32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1234, -32'sd5};
    vb = '{32'd7, 32'd7, -32'sd7, -32'sd7, -32'sd100, 32'hFFFF_FFFF,
           32'd1, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0};
    eq = '{32'd14, -32'sd14, -32'sd14, 32'd14, 32'd0, 32'h8000_0000,
           32'h8000_0000, 32'h3FFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    er = '{32'd2, -32'sd2, 32'd2, -32'sd2, 32'd7, 32'd0,
           32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1234, -32'sd5};
    // {div_by_zero, overflow}
    ef = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
           2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 12; i++) begin
      run_op(va[i], vb[i], q, r, dz, ov, lat, bcnt);
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        failures++;
        $display("FAIL directed_%0d: %0d/%0d gave q=%0d r=%0d required q=%0d r=%0d", i,
                 $signed(va[i]), $signed(vb[i]), $signed(q), $signed(r),
                 $signed(eq[i]), $signed(er[i]));
      end
      checks++;
      if ({dz, ov} !== ef[i]) begin
        failures++;
        $display("FAIL directed_flags_%0d: dz/ov=%b required %b", i, {dz, ov}, ef[i]);
      end
      checks++;
      if (lat !== (ef[i][1] ? 2 : 34) || bcnt !== (ef[i][1] ? 2 : 34)) begin
        failures++;
        $display("FAIL directed_timing_%0d: latency=%0d busy=%0d required %0d", i, lat, bcnt,
                 ef[i][1] ? 2 : 34);
      end
    end
  endtask

  task automatic test_done_pulse;
    logic [31:0] q, r;
    logic dz, ov;
    int lat, bcnt;
    run_op(32'd50, 32'd6, q, r, dz, ov, lat, bcnt);
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.Quotient !== 32'd8 || bus.Remainder !== 32'd2) begin
      failures++;
      $display("FAIL done_pulse_hold: done=%b q=%0d r=%0d required 0 8 2",
               bus.done, bus.Quotient, bus.Remainder);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    logic dz, ov;
    int lat, bcnt, dones;
    run_op(32'd100, 32'd7, q, r, dz, ov, lat, bcnt);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.Dividend = 32'd1000; bus.Divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 4'b0000 ||
        bus.Quotient !== 32'h0 || bus.Remainder !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h required all 0",
               bus.busy, bus.done, bus.Quotient, bus.Remainder);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: done pulses=%0d required 0", dones);
    end
    run_op(32'd1000, 32'd3, q, r, dz, ov, lat, bcnt);
    checks++;
    if (q !== 32'd333 || r !== 32'd1 || lat !== 34) begin
      failures++;
      $display("FAIL reset_mid_recover: q=%0d r=%0d lat=%0d required 333 1 34", q, r, lat);
    end
  endtask

  task automatic test_reset_priority;
    int dones;
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.Dividend = 32'd5; bus.Divisor = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: busy=%b required 0", bus.busy);
    end
    @(negedge clk); rst = 1'b0; bus.start = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_priority_idle: active cycles=%0d required 0", dones);
    end
  endtask

  // Start held high with operands changing every cycle; accepts fall at edges 0,36,72,108
  task automatic test_back_to_back;
    logic [31:0] oa [144];
    logic [31:0] ob [144];
    logic [31:0] q, r;
    logic dz, ov;
    logic exp_done;
    int k;
    for (int j = 0; j < 144; j++) begin
      k = 1000 + 37 * j;
      oa[j] = (j % 3 == 0) ? 32'(-k) : 32'(k);
      ob[j] = (j % 2 == 1) ? 32'(3 + j) : 32'(-(5 + j));
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 144; j++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.Dividend = oa[j]; bus.Divisor = ob[j];
      @(posedge clk); #1;
      exp_done = (j >= 34) && ((j - 34) % 36 == 0);
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done_edge_%0d: done=%b required %b", j, bus.done, exp_done);
      end
      if (exp_done) begin
        ref_div(oa[j-34], ob[j-34], q, r, dz, ov);
        checks++;
        if (bus.Quotient !== q || bus.Remainder !== r) begin
          failures++;
          $display("FAIL b2b_result_edge_%0d: q=%0d r=%0d required q=%0d r=%0d", j,
                   $signed(bus.Quotient), $signed(bus.Remainder), $signed(q), $signed(r));
        end
      end
    end
    @(negedge clk); bus.start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er;
    logic dz, ov, edz, eov;
    int lat, bcnt, bad;
    logic [31:0] pool [5];
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      k_pick: begin
        int sel;
        sel = $urandom_range(0, 9);
        a = (sel < 5) ? pool[sel] : 32'($urandom);
        sel = $urandom_range(0, 9);
        b = (sel < 5) ? pool[sel] : 32'($urandom) >> $urandom_range(0, 31);
      end
      run_op(a, b, q, r, dz, ov, lat, bcnt);
      ref_div(a, b, eq, er, edz, eov);
      checks++;
      if (q !== eq || r !== er || dz !== edz || ov !== eov) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: %h/%h gave q=%h r=%h dz=%b ov=%b required q=%h r=%h dz=%b ov=%b",
                   i, a, b, q, r, dz, ov, eq, er, edz, eov);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    test_reset();
    test_directed();
    test_done_pulse();
    test_reset_mid();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
